// File: rtl/memory_access_controller_if.sv
// Processor request/response and memory-side signals of the memory access controller.
// The controller uses the slave modport; the processor/memory side uses master.
interface memory_access_controller_if;
    logic        req;
    logic        req_write;
    logic [5:0]  req_address;
    logic [31:0] req_write_data;
    logic        busy;
    logic        ack;
    logic        error;
    logic [31:0] read_data;
    logic [6:0]  mem_address;
    logic [31:0] mem_in;
    logic [31:0] mem_out;
    logic        read_h_write_l;
    logic        memory_function_complete;

    modport master (
        output req, req_write, req_address, req_write_data,
        output mem_out, memory_function_complete,
        input  busy, ack, error, read_data,
        input  mem_address, mem_in, read_h_write_l
    );

    modport slave (
        input  req, req_write, req_address, req_write_data,
        input  mem_out, memory_function_complete,
        output busy, ack, error, read_data,
        output mem_address, mem_in, read_h_write_l
    );
endinterface

// File: rtl/memory_access_controller.sv
// Single-word memory access sequencer: select and address first, then strobe,
// release strobe before select, and report completion or timeout with a one-cycle Ack.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | select deasserted, waiting for a request
// ST_SETUP  | address/data driven with select asserted, strobe inactive
// ST_ACCESS | strobe active for writes, waiting for completion or timeout
// ST_HOLD   | strobe released, select still asserted
// ST_DONE   | select released, Ack (and Error on timeout) pulsed
module memory_access_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                          clk_sys,
    input  logic                          rst,
    memory_access_controller_if.slave     bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic       is_write;
    logic [3:0] wait_cnt;
    logic       timeout_flag;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state              <= ST_IDLE;
            is_write           <= 1'b0;
            wait_cnt           <= 4'd0;
            timeout_flag       <= 1'b0;
            bus.busy           <= 1'b0;
            bus.ack            <= 1'b0;
            bus.error          <= 1'b0;
            bus.read_data      <= 32'd0;
            bus.mem_address    <= 7'h40;
            bus.mem_in         <= 32'd0;
            bus.read_h_write_l <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        is_write        <= bus.req_write;
                        bus.mem_address <= {1'b0, bus.req_address};
                        // reads leave the last store data on the memory input bus
                        if (bus.req_write) begin
                            bus.mem_in <= bus.req_write_data;
                        end
                        bus.busy <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bus.read_h_write_l <= ~is_write;
                    state              <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.memory_function_complete) begin
                        if (!is_write) begin
                            bus.read_data <= bus.mem_out;
                        end
                        bus.read_h_write_l <= 1'b1;
                        state              <= ST_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // this cycle brings the count to TIMEOUT_CYCLES
                        wait_cnt           <= wait_cnt + 4'd1;
                        timeout_flag       <= 1'b1;
                        bus.read_h_write_l <= 1'b1;
                        state              <= ST_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_HOLD: begin
                    bus.mem_address[6] <= 1'b1;
                    bus.ack            <= 1'b1;
                    bus.error          <= timeout_flag;
                    state              <= ST_DONE;
                end
                ST_DONE: begin
                    bus.ack      <= 1'b0;
                    bus.error    <= 1'b0;
                    bus.busy     <= 1'b0;
                    wait_cnt     <= 4'd0;
                    timeout_flag <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: behavioural memory, transaction-timing model
// checked every cycle, plus directed transactions with literal expectations.
module tb_memory_access_controller;
    localparam int TIMEOUT = 15;

    logic clk_sys = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    memory_access_controller_if bus ();

    memory_access_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // behavioural memory: garbage on the bus while deselected, write commits on completion
    logic [31:0] mem_arr [64];
    assign bus.mem_out = bus.mem_address[6] ? 32'hBAD0_BAD0 : mem_arr[bus.mem_address[5:0]];
    always @(posedge clk_sys) begin
        if (!bus.mem_address[6] && !bus.read_h_write_l && bus.memory_function_complete)
            mem_arr[bus.mem_address[5:0]] <= bus.mem_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // transaction-level model: a transaction sampled at edge s with access length L
    // finishes (Ack) after edge s+L+2 and a new Req is accepted from edge s+L+4 on
    int          cyc = 0;
    int          m_s = 0;
    int          m_alen = 0;
    int          m_done = 0;
    bit          m_active = 1'b0;
    bit          m_w = 1'b0;
    bit          m_to = 1'b0;
    logic [5:0]  m_addr = 6'd0;
    logic [31:0] m_data = 32'd0;
    logic [5:0]  exp_addr = 6'd0;
    logic [31:0] exp_rd = 32'd0;
    logic [31:0] exp_mem_in = 32'd0;
    logic [31:0] exp_mem [64];

    always @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            m_active   = 1'b0;
            exp_addr   = 6'd0;
            exp_rd     = 32'd0;
            exp_mem_in = 32'd0;
        end else begin
            cyc++;
            if (m_active && !m_to && cyc == m_s + m_alen + 1) begin
                if (m_w) exp_mem[m_addr] = m_data;
                else     exp_rd = exp_mem[m_addr];
            end
            if ((!m_active || cyc >= m_done + 2) && bus.req) begin
                m_active = 1'b1;
                m_s      = cyc;
                m_w      = bus.req_write;
                m_addr   = bus.req_address;
                m_data   = bus.req_write_data;
                m_to     = !bus.memory_function_complete;
                m_alen   = m_to ? TIMEOUT : 1;
                m_done   = m_s + m_alen + 2;
                exp_addr = m_addr;
                if (m_w) exp_mem_in = m_data;
            end
        end
    end

    always @(negedge clk_sys) begin
        bit e_busy, e_ack, e_cs_n, e_rhw;
        if (!rst && chk_en) begin
            e_busy = m_active && cyc >= m_s && cyc <= m_done;
            e_ack  = m_active && cyc == m_done;
            e_cs_n = !(m_active && cyc >= m_s && cyc <= m_done - 1);
            e_rhw  = !(m_active && m_w && cyc >= m_s + 1 && cyc <= m_s + m_alen);
            chk("cyc_busy", 32'(bus.busy), 32'(e_busy));
            chk("cyc_ack", 32'(bus.ack), 32'(e_ack));
            chk("cyc_error", 32'(bus.error), 32'(e_ack && m_to));
            chk("cyc_mem_address", 32'(bus.mem_address), 32'({e_cs_n, exp_addr}));
            chk("cyc_read_h_write_l", 32'(bus.read_h_write_l), 32'(e_rhw));
            chk("cyc_mem_in", bus.mem_in, exp_mem_in);
            chk("cyc_read_data", bus.read_data, exp_rd);
        end
    end

    // called one cycle after the sampling edge (cycle 1); Ack cycle number returned in lat
    task automatic wait_ack(input int budget, output int lat, output logic err, output logic cs_n);
        int n = 1;
        lat  = -1;
        err  = 1'b0;
        cs_n = 1'b0;
        while (n <= budget && lat < 0) begin
            if (bus.ack) begin
                lat  = n;
                err  = bus.error;
                cs_n = bus.mem_address[6];
            end else begin
                @(posedge clk_sys); #1;
                n++;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_wait: no Ack within %0d cycles", budget);
        end
    endtask

    task automatic run_txn(input bit w, input logic [5:0] a, input logic [31:0] d, input int budget,
                           output int lat, output logic err, output logic cs_n);
        bus.req_write      = w;
        bus.req_address    = a;
        bus.req_write_data = d;
        bus.req            = 1'b1;
        @(posedge clk_sys); #1;
        bus.req = 1'b0;
        wait_ack(budget, lat, err, cs_n);
        @(posedge clk_sys); #1;
    endtask

    initial begin
        int   lat, t1, t2, n, extra;
        logic err, cs_n;
        rst = 1'b1;
        bus.req = 1'b0;
        bus.req_write = 1'b0;
        bus.req_address = 6'd0;
        bus.req_write_data = 32'd0;
        bus.memory_function_complete = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("rst_mem_address", 32'(bus.mem_address), 32'h40);
        chk("rst_read_h_write_l", 32'(bus.read_h_write_l), 32'd1);
        chk("rst_mem_in", bus.mem_in, 32'd0);
        chk("rst_read_data", bus.read_data, 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk_sys);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk_sys); #1;

        // write then read back
        run_txn(1'b1, 6'd5, 32'hDEADBEEF, 20, lat, err, cs_n);
        chk("wr5_latency", 32'(lat), 32'd4);
        chk("wr5_error", 32'(err), 32'd0);
        run_txn(1'b0, 6'd5, 32'h0, 20, lat, err, cs_n);
        chk("rd5_latency", 32'(lat), 32'd4);
        chk("rd5_error", 32'(err), 32'd0);
        chk("rd5_data", bus.read_data, 32'hDEADBEEF);
        chk("rd5_mem_in_held", bus.mem_in, 32'hDEADBEEF);

        // timeout on read of addr 9
        bus.memory_function_complete = 1'b0;
        run_txn(1'b0, 6'd9, 32'h0, 40, lat, err, cs_n);
        chk("to_latency", 32'(lat), 32'(TIMEOUT + 3));
        chk("to_error", 32'(err), 32'd1);
        chk("to_cs_released", 32'(cs_n), 32'd1);
        chk("to_data_kept", bus.read_data, 32'hDEADBEEF);
        bus.memory_function_complete = 1'b1;

        // back-to-back reads of 0 then 63 with Req held high
        run_txn(1'b1, 6'd0, 32'hA5A5_0000, 20, lat, err, cs_n);
        run_txn(1'b1, 6'd63, 32'h0F0F_F0F0, 20, lat, err, cs_n);
        bus.req_write = 1'b0;
        bus.req_address = 6'd0;
        bus.req = 1'b1;
        @(posedge clk_sys); #1;
        bus.req_address = 6'd63;
        n = 1; t1 = -1; t2 = -1;
        while (n <= 40 && t2 < 0) begin
            if (bus.ack) begin
                if (t1 < 0) begin
                    t1 = n;
                    chk("b2b_first_data", bus.read_data, 32'hA5A5_0000);
                end else begin
                    t2 = n;
                    chk("b2b_second_data", bus.read_data, 32'h0F0F_F0F0);
                    bus.req = 1'b0;
                end
            end
            if (t2 < 0) begin
                @(posedge clk_sys); #1;
                n++;
            end
        end
        chk("b2b_first_latency", 32'(t1), 32'd4);
        chk("b2b_ack_spacing", 32'(t2 - t1), 32'd5);
        extra = 0;
        repeat (12) begin
            @(posedge clk_sys); #1;
            if (bus.ack) extra++;
        end
        chk("b2b_no_extra_ack", 32'(extra), 32'd0);
        chk("b2b_idle_busy", 32'(bus.busy), 32'd0);

        // reset during ACCESS of a write to addr 12
        run_txn(1'b1, 6'd12, 32'hCAFE_0012, 20, lat, err, cs_n);
        bus.memory_function_complete = 1'b0;
        bus.req_write = 1'b1;
        bus.req_address = 6'd12;
        bus.req_write_data = 32'h5555_AAAA;
        bus.req = 1'b1;
        @(posedge clk_sys); #1;
        bus.req = 1'b0;
        @(posedge clk_sys); #1;
        chk("wr12_strobe_active", 32'(bus.read_h_write_l), 32'd0);
        chk("wr12_cs_active", 32'(bus.mem_address[6]), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_read_h_write_l", 32'(bus.read_h_write_l), 32'd1);
        chk("midrst_mem_address", 32'(bus.mem_address), 32'h40);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_mem_in", bus.mem_in, 32'd0);
        chk("midrst_read_data", bus.read_data, 32'd0);
        extra = 0;
        repeat (3) begin
            @(posedge clk_sys); #1;
            if (bus.ack) extra++;
        end
        chk("midrst_no_ack", 32'(extra), 32'd0);
        bus.req_write = 1'b0;
        bus.req = 1'b1;
        bus.memory_function_complete = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        @(posedge clk_sys); #1;
        chk("req_after_rst_busy", 32'(bus.busy), 32'd1);
        bus.req = 1'b0;
        wait_ack(20, lat, err, cs_n);
        chk("rd12_latency", 32'(lat), 32'd4);
        chk("rd12_data", bus.read_data, 32'hCAFE_0012);
        @(posedge clk_sys); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
